// File: rtl/fetch_pkg.sv
// Shared constants, entry layout and helpers for the instruction fetch front end.
// Optional misalignment flagging is enabled by defining FETCH_MISALIGN_CHK_EN.
package fetch_pkg;

    localparam int INST_W       = 32;
    localparam int PC_INC       = 4;
    localparam int XLEN_DEFAULT = 32;

    // Entry layout at the default PC width; the FIFO builds a width-matched copy.
    typedef struct packed {
        logic [INST_W-1:0]       data;
        logic [XLEN_DEFAULT-1:0] pc;
        logic                    misalign;
    } fetch_entry_t;

    function automatic logic is_misaligned(input logic [1:0] pc_lsb);
        return pc_lsb != 2'b00;
    endfunction

endpackage

// File: rtl/inst_fetch_unit_if.sv
// Fetch-to-decode valid/ready handshake. inst_misalign exists only when
// FETCH_MISALIGN_CHK_EN is defined.
interface inst_fetch_unit_if
    import fetch_pkg::*;
#(
    parameter int XLEN = 32
) ();

    logic              inst_valid;
    logic              inst_ready;
    logic [INST_W-1:0] inst_data;
    logic [XLEN-1:0]   inst_pc;
    logic [XLEN-1:0]   inst_npc;
`ifdef FETCH_MISALIGN_CHK_EN
    logic              inst_misalign;
`endif

    modport master (
        input  inst_ready,
        output inst_valid, inst_data, inst_pc, inst_npc
`ifdef FETCH_MISALIGN_CHK_EN
        , inst_misalign
`endif
    );

    modport slave (
        output inst_ready,
        input  inst_valid, inst_data, inst_pc, inst_npc
`ifdef FETCH_MISALIGN_CHK_EN
        , inst_misalign
`endif
    );

endinterface

// File: rtl/fetch_fifo.sv
// Fetch buffer: push/pop/flush FIFO with registered head outputs (no path from push data
// to the head outputs). FETCH_MISALIGN_CHK_EN adds a per-entry misalign flag.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [INST_W-1:0]        push_data,
    input  logic [XLEN-1:0]          push_pc,
`ifdef FETCH_MISALIGN_CHK_EN
    input  logic                     push_misalign,
`endif
    input  logic                     pop,
    input  logic                     flush,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     head_valid,
    output logic [INST_W-1:0]        head_data,
    output logic [XLEN-1:0]          head_pc,
    output logic [XLEN-1:0]          head_npc
`ifdef FETCH_MISALIGN_CHK_EN
    , output logic                   head_misalign
`endif
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef struct packed {
`ifdef FETCH_MISALIGN_CHK_EN
        logic              misalign;
`endif
        logic [XLEN-1:0]   pc;
        logic [INST_W-1:0] data;
    } entry_t;

    entry_t          mem [DEPTH];
    entry_t          push_entry;
    entry_t          head_reg, head_next;
    logic [XLEN-1:0] head_npc_reg, head_npc_next;
    logic [PW-1:0]   wr_ptr_reg, wr_ptr_next;
    logic [PW-1:0]   rd_ptr_reg, rd_ptr_next;
    logic [PW-1:0]   rd_ptr_inc;
    logic [CW-1:0]   count_reg, count_next;
    logic [DEPTH-1:0] slot_we;
    logic            push_eff;
    logic            pop_eff;

    assign head_valid = (count_reg != '0);
    assign push_eff   = push && !flush;
    assign pop_eff    = pop && head_valid && !flush;
    assign rd_ptr_inc = rd_ptr_reg + 1'b1;

    always_comb begin
        push_entry      = '0;
        push_entry.data = push_data;
        push_entry.pc   = push_pc;
`ifdef FETCH_MISALIGN_CHK_EN
        push_entry.misalign = push_misalign;
`endif
    end

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot_we
        assign slot_we[gi] = push_eff && (wr_ptr_reg == PW'(gi));
    end

    always_comb begin
        wr_ptr_next   = wr_ptr_reg;
        rd_ptr_next   = rd_ptr_reg;
        count_next    = count_reg;
        head_next     = head_reg;
        head_npc_next = head_npc_reg;
        if (flush) begin
            wr_ptr_next = '0;
            rd_ptr_next = '0;
            count_next  = '0;
        end else begin
            if (push_eff) wr_ptr_next = wr_ptr_reg + 1'b1;
            if (pop_eff)  rd_ptr_next = rd_ptr_inc;
            count_next = count_reg + CW'(push_eff) - CW'(pop_eff);
            // The head register is reloaded from the incoming word when it is about to
            // become the oldest entry, otherwise from the next stored slot.
            if (push_eff && (count_reg == '0 || (pop_eff && count_reg == CW'(1)))) begin
                head_next     = push_entry;
                head_npc_next = push_pc + XLEN'(PC_INC);
            end else if (pop_eff && count_reg > CW'(1)) begin
                head_next     = mem[rd_ptr_inc];
                head_npc_next = mem[rd_ptr_inc].pc + XLEN'(PC_INC);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            count_reg    <= '0;
            head_reg     <= '0;
            head_npc_reg <= XLEN'(PC_INC);
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            wr_ptr_reg   <= wr_ptr_next;
            rd_ptr_reg   <= rd_ptr_next;
            count_reg    <= count_next;
            head_reg     <= head_next;
            head_npc_reg <= head_npc_next;
            for (int i = 0; i < DEPTH; i++) begin
                if (slot_we[i]) mem[i] <= push_entry;
            end
        end
    end

    assign count     = count_reg;
    assign head_data = head_reg.data;
    assign head_pc   = head_reg.pc;
    assign head_npc  = head_npc_reg;
`ifdef FETCH_MISALIGN_CHK_EN
    assign head_misalign = head_reg.misalign;
`endif

endmodule

// File: rtl/inst_fetch_unit.sv
// Instruction fetch front end: owns the fetch PC, issues reads to a 1-cycle ROM under a
// credit rule and buffers returned words for decode. Optional macro: FETCH_MISALIGN_CHK_EN.
module inst_fetch_unit
    import fetch_pkg::*;
#(
    parameter int              XLEN       = 32,
    parameter int              ROM_AW     = 6,
    parameter int              FIFO_DEPTH = 2,
    parameter logic [XLEN-1:0] RESET_PC   = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              redirect_valid,
    input  logic [XLEN-1:0]   redirect_pc,
    output logic [ROM_AW-1:0] rom_addr,
    output logic              rom_en,
    input  logic [INST_W-1:0] rom_rdata,
    inst_fetch_unit_if.master dec
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int OW = CW + 1;

    logic [XLEN-1:0] pc_reg, pc_next;
    logic [XLEN-1:0] inflight_pc_reg, inflight_pc_next;
    logic            inflight_reg, inflight_next;
    logic [CW-1:0]   fifo_count;
    logic [OW-1:0]   occupancy;
    logic            pop;
    logic            push;

    // Every word already buffered or still in the ROM pipe holds a FIFO slot, so an
    // issue is only made when a slot is guaranteed to be free on return.
    assign pop       = dec.inst_valid && dec.inst_ready;
    assign occupancy = OW'(fifo_count) + OW'(inflight_reg) - OW'(pop);
    assign rom_en    = !rst && !redirect_valid && (occupancy < OW'(FIFO_DEPTH));
    assign push      = inflight_reg && !redirect_valid;
    assign rom_addr  = pc_reg[ROM_AW+1:2];

    always_comb begin
        pc_next          = pc_reg;
        inflight_next    = 1'b0;
        inflight_pc_next = inflight_pc_reg;
        if (redirect_valid) begin
            pc_next = redirect_pc;
        end else if (rom_en) begin
            inflight_next    = 1'b1;
            inflight_pc_next = pc_reg;
            pc_next          = pc_reg + XLEN'(PC_INC);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_reg          <= RESET_PC;
            inflight_reg    <= 1'b0;
            inflight_pc_reg <= '0;
        end else begin
            pc_reg          <= pc_next;
            inflight_reg    <= inflight_next;
            inflight_pc_reg <= inflight_pc_next;
        end
    end

    fetch_fifo #(
        .XLEN  (XLEN),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk           (clk),
        .rst           (rst),
        .push          (push),
        .push_data     (rom_rdata),
        .push_pc       (inflight_pc_reg),
`ifdef FETCH_MISALIGN_CHK_EN
        .push_misalign (is_misaligned(inflight_pc_reg[1:0])),
`endif
        .pop           (pop),
        .flush         (redirect_valid),
        .count         (fifo_count),
        .head_valid    (dec.inst_valid),
        .head_data     (dec.inst_data),
        .head_pc       (dec.inst_pc),
        .head_npc      (dec.inst_npc)
`ifdef FETCH_MISALIGN_CHK_EN
        , .head_misalign (dec.inst_misalign)
`endif
    );

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Self-checking bench for inst_fetch_unit: directed vector table, reset corner case and a
// randomized run against a stream-level reference model. Honours FETCH_MISALIGN_CHK_EN.
module tb_inst_fetch_unit;
    import fetch_pkg::*;

    localparam int XLEN       = 32;
    localparam int ROM_AW     = 6;
    localparam int FIFO_DEPTH = 2;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              redirect_valid = 1'b0;
    logic [XLEN-1:0]   redirect_pc = '0;
    logic [ROM_AW-1:0] rom_addr;
    logic              rom_en;
    logic [31:0]       rom_rdata = '0;

    inst_fetch_unit_if #(.XLEN(XLEN)) dec ();

    inst_fetch_unit #(
        .XLEN       (XLEN),
        .ROM_AW     (ROM_AW),
        .FIFO_DEPTH (FIFO_DEPTH),
        .RESET_PC   (32'h0)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .rom_addr       (rom_addr),
        .rom_en         (rom_en),
        .rom_rdata      (rom_rdata),
        .dec            (dec)
    );

    always #5 clk = ~clk;

    // Synchronous ROM, ROM[i] = 0x1000_0000 + i
    always @(posedge clk) begin
        if (rom_en) rom_rdata <= 32'h1000_0000 + {26'd0, rom_addr};
    end

    function automatic logic [31:0] rom_word(input logic [31:0] pc);
        return 32'h1000_0000 + ((pc >> 2) & 32'h3F);
    endfunction

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic check_head(input string tag, input logic [31:0] pc);
        fetch_entry_t e;
        e.pc       = pc;
        e.data     = rom_word(pc);
        e.misalign = (pc[1:0] != 2'b00);
        check({tag, " inst_pc"}, dec.inst_pc, e.pc);
        check({tag, " inst_data"}, dec.inst_data, e.data);
        check({tag, " inst_npc"}, dec.inst_npc, e.pc + 32'd4);
`ifdef FETCH_MISALIGN_CHK_EN
        check({tag, " inst_misalign"}, 32'(dec.inst_misalign), 32'(e.misalign));
`endif
    endtask

    typedef struct {
        logic        ready;
        logic        redir;
        logic [31:0] rpc;
        logic        exp_en;
        logic        exp_valid;
        logic [31:0] exp_pc;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic r, input logic d, input logic [31:0] rpc,
                       input logic en, input logic v, input logic [31:0] pc);
        vec_t t;
        t.ready = r; t.redir = d; t.rpc = rpc;
        t.exp_en = en; t.exp_valid = v; t.exp_pc = pc;
        vecs.push_back(t);
    endtask

    initial begin
        logic        r, d;
        logic [31:0] rpc, exp_pc;
        int          since, outstanding, transfers;
        logic        pop_now, exp_en;

        // reset stream, first word after 2 edges, one per cycle
        add(1, 0, 0, 1, 0, 0);
        add(1, 0, 0, 1, 1, 32'h0);
        add(1, 0, 0, 1, 1, 32'h4);
        add(1, 0, 0, 1, 1, 32'h8);
        // back-pressure: FIFO fills, issue stops, head holds
        for (int i = 0; i < 10; i++) add(0, 0, 0, 0, 1, 32'h8);
        add(1, 0, 0, 1, 1, 32'hC);
        add(1, 0, 0, 1, 1, 32'h10);
        add(1, 0, 0, 1, 1, 32'h14);
        // redirect with a word in flight
        add(0, 1, 32'h40, 0, 0, 0);
        add(1, 0, 0, 1, 0, 0);
        add(1, 0, 0, 1, 1, 32'h40);
        add(1, 0, 0, 1, 1, 32'h44);
        // redirect with same-cycle pop and returning data, then ROM alias
        add(1, 1, 32'hFC, 0, 0, 0);
        add(1, 0, 0, 1, 0, 0);
        add(1, 0, 0, 1, 1, 32'hFC);
        add(1, 0, 0, 1, 1, 32'h100);
        add(1, 0, 0, 1, 1, 32'h104);
        // misaligned target
        add(1, 1, 32'h22, 0, 0, 0);
        add(1, 0, 0, 1, 0, 0);
        add(1, 0, 0, 1, 1, 32'h22);
        add(1, 0, 0, 1, 1, 32'h26);

        dec.inst_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset inst_valid", 32'(dec.inst_valid), 32'h0);
        check("reset inst_data", dec.inst_data, 32'h0);
        check("reset inst_pc", dec.inst_pc, 32'h0);
        check("reset inst_npc", dec.inst_npc, 32'h4);
        check("reset rom_en", 32'(rom_en), 32'h0);
        rst = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            dec.inst_ready = vecs[i].ready;
            redirect_valid = vecs[i].redir;
            redirect_pc    = vecs[i].rpc;
            #1;
            check($sformatf("row%0d rom_en", i), 32'(rom_en), 32'(vecs[i].exp_en));
            @(posedge clk);
            #1;
            check($sformatf("row%0d inst_valid", i), 32'(dec.inst_valid), 32'(vecs[i].exp_valid));
            if (vecs[i].exp_valid) check_head($sformatf("row%0d", i), vecs[i].exp_pc);
            $display("row %0d: ready=%0b redir=%0b valid=%0b pc=0x%08h data=0x%08h",
                     i, vecs[i].ready, vecs[i].redir, dec.inst_valid, dec.inst_pc, dec.inst_data);
        end

        // asynchronous reset in the middle of a stream
        dec.inst_ready = 1'b1;
        redirect_valid = 1'b0;
        #2;
        check("pre-reset inst_valid", 32'(dec.inst_valid), 32'h1);
        rst = 1'b1;
        #1;
        check("midrst inst_valid", 32'(dec.inst_valid), 32'h0);
        check("midrst inst_data", dec.inst_data, 32'h0);
        check("midrst inst_pc", dec.inst_pc, 32'h0);
        check("midrst inst_npc", dec.inst_npc, 32'h4);
        check("midrst rom_en", 32'(rom_en), 32'h0);
`ifdef FETCH_MISALIGN_CHK_EN
        check("midrst inst_misalign", 32'(dec.inst_misalign), 32'h0);
`endif
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check("post-reset rom_en", 32'(rom_en), 32'h1);
        @(posedge clk);
        #1;
        check("post-reset edge0 inst_valid", 32'(dec.inst_valid), 32'h0);
        @(posedge clk);
        #1;
        check("post-reset edge1 inst_valid", 32'(dec.inst_valid), 32'h1);
        check_head("post-reset", 32'h0);
        $display("reset restart: valid=%0b pc=0x%08h data=0x%08h",
                 dec.inst_valid, dec.inst_pc, dec.inst_data);

        // randomized run: words 0 (buffered) and 4 (in the ROM) are outstanding here
        exp_pc      = 32'h0;
        since       = 100;
        outstanding = 2;
        transfers   = 0;
        for (int c = 0; c < 600; c++) begin
            r   = ($urandom_range(0, 3) != 0);
            d   = ($urandom_range(0, 19) == 0);
            rpc = $urandom;
            dec.inst_ready = r;
            redirect_valid = d;
            redirect_pc    = rpc;
            #1;
            check($sformatf("rnd%0d inst_valid", c), 32'(dec.inst_valid), 32'(since >= 2));
            pop_now = dec.inst_valid && r && !d;
            exp_en  = !d && ((outstanding - int'(pop_now)) < FIFO_DEPTH);
            check($sformatf("rnd%0d rom_en", c), 32'(rom_en), 32'(exp_en));
            if (pop_now) begin
                check_head($sformatf("rnd%0d", c), exp_pc);
                $display("rnd %0d: accept pc=0x%08h data=0x%08h npc=0x%08h",
                         c, dec.inst_pc, dec.inst_data, dec.inst_npc);
                exp_pc = exp_pc + 32'd4;
                transfers++;
            end
            if (d) begin
                exp_pc      = rpc;
                outstanding = 0;
                since       = 0;
            end else begin
                outstanding = outstanding - int'(pop_now) + int'(exp_en);
                if (since < 100) since++;
            end
            @(posedge clk);
            #1;
        end
        check("random transfers seen", 32'(transfers > 100), 32'h1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/inst_fetch_unit.md
Name: inst_fetch_unit

Overview:
- Parametrised instruction-fetch front end: owns the fetch PC and drives an external synchronous instruction ROM (1-cycle read latency).
- Buffers returned words in a small FIFO and presents them to decode over a valid/ready handshake.
- Supports redirect (branch/jump) with flush of all buffered and in-flight fetches.
- Sits between the instruction ROM and the decode stage; replaces the single-register PC fetcher.

Parameters:
XLEN, 32, width of PC and PC outputs
ROM_AW, 6, ROM word-address width (ROM depth = 2**ROM_AW words)
FIFO_DEPTH, 2, fetch buffer entries (power of 2, >=2)
RESET_PC, 0, PC value loaded on reset

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  reset, asynchronous, active-high
redirect_valid  in  1  redirect request this cycle
redirect_pc  in  XLEN  redirect target
rom_addr  out  ROM_AW  word address to ROM, = pc_q[ROM_AW+1:2]
rom_en  out  1  ROM read enable (issue this cycle)
rom_rdata  in  32  ROM data, valid the cycle after rom_en
inst_valid  out  1  FIFO head valid
inst_ready  in  1  decode accepts head
inst_data  out  32  head instruction word
inst_pc  out  XLEN  PC of head instruction
inst_npc  out  XLEN  inst_pc + 4 (mod 2**XLEN)

Behaviour:
- Reset (async): pc_q=RESET_PC, FIFO empty (count=0, pointers 0, storage 0), inflight=0. Outputs: inst_valid=0, inst_data=0, inst_pc=0, inst_npc=4, rom_en=0 during reset.
- Issue: rom_en = !rst && !redirect_valid && (count + inflight - pop) < FIFO_DEPTH, where pop = inst_valid && inst_ready. On issue: inflight<=1, inflight_pc<=pc_q, pc_q<=pc_q+4. With no issue, inflight<=0.
- Return: when inflight=1, rom_rdata/inflight_pc are pushed into the FIFO tail in the same cycle, unless that cycle has a redirect.
- Credit rule guarantees no push into a full FIFO; push and pop in the same cycle leave count unchanged.
- Pop: on inst_valid && inst_ready the head advances. inst_data/inst_pc/inst_npc are registered FIFO head values, with no combinational path from rom_rdata.
- Redirect (highest priority): flush FIFO (count=0), kill inflight (inflight<=0, no push), pc_q<=redirect_pc, no issue that cycle. A pop in the same cycle is ignored, and inst_valid falls on the next cycle.
- Latency: from reset release or redirect, rom_en rises at edge 0, data is pushed at edge 1, and inst_valid=1 after edge 1, so the first instruction is visible 2 cycles later.
- Throughput: 1 instruction/cycle sustained while inst_ready=1 and FIFO_DEPTH>=2.
- Back-pressure: with inst_ready=0 the FIFO fills to FIFO_DEPTH, after which rom_en=0 and pc_q holds. No words are lost or duplicated.
- ROM wrap: rom_addr uses only pc_q[ROM_AW+1:2], so PC beyond ROM depth aliases modulo 2**ROM_AW words. pc_q itself wraps mod 2**XLEN.
- pc_q[1:0] is carried unchanged; ROM indexing ignores it.
- Reset asserted mid-operation discards everything immediately; no partial state survives.

Optional Feature:
- Macro: FETCH_MISALIGN_CHK_EN.
- Defined:
  - Adds output port inst_misalign (1 bit), registered alongside each FIFO entry; =1 when that entry's PC[1:0] != 0.
  - A redirect with redirect_pc[1:0] != 0 is still accepted; the flagged entry is delivered, and decode raises the trap.
  - Reset value 0.
- Undefined: port absent; low PC bits are ignored silently.

Decomposition:
- Shared package fetch_pkg:
  - INST_W=32 constant and PC_INC=4 constant.
  - fetch_entry_t struct {data[31:0], pc[XLEN-1:0], misalign}.
- One natural sub-module: fetch_fifo (parametrised FIFO_DEPTH; push/pop/flush, count, registered head outputs).
- PC/issue/credit logic lives in inst_fetch_unit.

Test Plan:
- Reset release, ROM[i]=0x1000_0000+i, inst_ready=1 -> inst_valid at cycle 2; stream inst_pc 0,4,8,... with inst_data 0x10000000,0x10000001,... one per cycle; inst_npc=inst_pc+4.
- Hold inst_ready=0 for 10 cycles after first valid -> FIFO fills to 2, rom_en=0, head stays inst_pc=0. Release -> pcs 0,4,8 in order, none dropped or duplicated.
- redirect_valid=1, redirect_pc=0x40 while FIFO full and a fetch is inflight -> next cycle inst_valid=0; 2 cycles later inst_pc=0x40, data=ROM[16]. Stale PCs are never presented.
- Redirect and pop in the same cycle, plus redirect on the cycle data returns -> returned word discarded, count=0, no stale entry.
- ROM_AW=6, redirect_pc=0xFC -> inst_pc 0xFC then 0x100; second word is ROM[0] (alias); inst_pc continues 0x100, 0x104.
- FETCH_MISALIGN_CHK_EN, redirect_pc=0x22 -> inst_pc=0x22 with inst_misalign=1, next 0x26 with inst_misalign=1. Assert rst mid-stream -> all outputs return to reset values immediately.
